// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder for the M stage.
// Accepts one request at a time, completes it LATENCY cycles later with a
// single-cycle ready_m pulse, and stalls the pipeline while a request is
// outstanding. Storage is 2**ADDR_BITS x 32-bit words, word addressed.
//
// Ports:
//   clk        in   clock, rising-edge
//   reset      in   asynchronous, active-high
//   req_m      in   request valid
//   we_m       in   1 = write, 0 = read
//   addr_m     in   byte address (bits [ADDR_BITS+1:2] select the word)
//   wdata_m    in   store data
//   rdata_m    out  load data (held until the next read completes)
//   ready_m    out  one-cycle completion pulse
//   stall_mem  out  req_m & ~ready_m
//   busy       out  transaction in flight (BUSY or DONE)
module dmem_responder #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_m,
  input  logic        we_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic [31:0] rdata_m,
  output logic        ready_m,
  output logic        stall_mem,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 r_state, w_next;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic [31:0]            r_mem [0:(1<<ADDR_BITS)-1];

  logic                   w_accept;
  logic                   w_to_done;
  logic                   w_we_eff;
  logic [ADDR_BITS-1:0]   w_idx;
  logic                   w_unused_addr;

  // Byte offset and bits above the storage depth are deliberately dropped.
  assign w_unused_addr = ^{addr_m[31:ADDR_BITS+2], addr_m[1:0]};

  assign w_accept  = (r_state == IDLE) && req_m;
  assign w_to_done = (r_state != DONE) && (w_next == DONE);
  // With LATENCY=1 the read happens on the accepting edge, so the live
  // inputs are used instead of the not-yet-captured registers.
  assign w_we_eff  = (r_state == IDLE) ? we_m : r_we;
  assign w_idx     = (r_state == IDLE) ? addr_m[ADDR_BITS+1:2] : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_m) w_next = (LATENCY == 1) ? DONE : BUSY;
      BUSY: if (r_cnt == 4'd1) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_we    <= we_m;
        r_addr  <= addr_m[ADDR_BITS+1:2];
        r_wdata <= wdata_m;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_state == DONE) begin
        r_cnt <= '0;
      end
      // Load data becomes visible on entry to DONE and then sits still;
      // writes never touch it.
      if (w_to_done && !w_we_eff) r_rdata <= r_mem[w_idx];
    end
  end

  // Storage is not reset. Commit happens on the edge that ends DONE; an
  // asynchronous reset pulls the state out of DONE first, so an abandoned
  // write never lands.
  always_ff @(posedge clk) begin
    if (r_state == DONE && r_we) r_mem[r_addr] <= r_wdata;
  end

  assign ready_m   = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign stall_mem = req_m & ~ready_m;
  assign rdata_m   = r_rdata;

endmodule
